fp_addsub_pipe: RTL and testbench
=================================

Name: fp_addsub_pipe

Overview:
Parametrised, pipelined IEEE-754-style floating-point adder/subtractor. It is the successor to the fixed FP32 adder, generalised to any exponent and mantissa width. It adds a runtime add/sub mode, round-to-nearest-even, special-value handling, exception flags and a valid/ready handshake with backpressure. It sits in the NLA datapath between the approximation-term generators and the accumulators.

Parameters:
EXP_W, 8, exponent field width (at least 4)
MAN_W, 23, stored mantissa width, excluding the hidden bit (at least 4)
W, EXP_W+MAN_W+1, total word width (derived; not overridable)

Ports:
clk_n  in  1  clock; all state updates on the falling edge of clk_n
rst_n  in  1  asynchronous, active-low reset
in_valid  in  1  operand pair valid
in_ready  out  1  block can accept an operand pair this cycle
op_sub  in  1  0 = a+b, 1 = a-b; sampled with the operands
a  in  W  operand A {sign, exp, man}
b  in  W  operand B
out_valid  out  1  result valid
out_ready  in  1  consumer accepts the result
result  out  W  sum or difference
flag_invalid  out  1  NaN produced by inf-inf, or a NaN input
flag_overflow  out  1  rounded result overflowed to inf
flag_zero  out  1  result is ±0

Behaviour:
- Reset: every pipeline valid bit clears; out_valid=0, result=0, all flags=0. in_ready=1 from the first falling edge after reset is released. A reset mid-operation discards all in-flight operations and produces no output for them.
- Handshake:
  - Transfer in: in_valid && in_ready. Transfer out: out_valid && out_ready.
  - stall = out_valid && !out_ready; in_ready = !stall. The whole pipeline freezes while stall is high; nothing is dropped or duplicated.
  - Bubbles advance freely: an empty stage never blocks upstream.
  - result and flags hold stable while out_valid=1 and out_ready=0.
- Latency: exactly 5 falling edges from input transfer to out_valid when there is no stall. Throughput is 1 op per cycle. Results leave in issue order.
- Stages:
  - S1: unpack; effective b sign = b.sign ^ op_sub; classify zero/inf/NaN; swap so the larger magnitude is "big" (compare exp, then mantissa); result sign = big sign.
  - S2: right-shift the small mantissa by the exponent difference into a MAN_W+4 path (hidden bit, mantissa, guard, round, sticky). Sticky ORs every shifted-out bit. A shift of MAN_W+3 or more yields only sticky.
  - S3: add the mantissas if the signs are equal, otherwise subtract (big-small, never negative); keep the carry.
  - S4: on carry, shift right 1 (folding into sticky) and exp+1. Otherwise left-normalise by the leading-zero count from fp_lzc and subtract the count from exp.
  - S5: round to nearest even, using guard and (round|sticky) with the LSB as tie-break. A rounding carry-out renormalises and increments exp. Then pack.
- Special cases, with priority top-down:
  - Any NaN input → canonical qNaN (sign 0, exp all ones, man MSB 1, rest 0), flag_invalid=1.
  - inf - inf (effective) → canonical qNaN, flag_invalid=1.
  - inf op finite, or same-sign infs → that inf.
  - Subnormal inputs are flushed to ±0 before S1.
  - Exact cancellation → +0.
  - ±0 + ±0 → -0 only if both effective signs are negative; otherwise +0.
  - Exp after rounding ≥ all-ones → ±inf, flag_overflow=1.
  - Exp ≤ 0 after normalisation → ±0 (flush), flag_zero=1.
- flag_zero is set for any ±0 result.
- Special-case decisions are made in S1 and carried as a bypass tag; the S5 pack overrides the datapath value.

Decomposition:
- Package fp_pkg: parameters EXP_W and MAN_W, the BIAS function, an exp_all_ones function, a canonical qNaN constant function, and the class enum {FP_ZERO, FP_NORM, FP_INF, FP_NAN}.
- One sub-module fp_lzc #(WIDTH): a combinational leading-zero counter with output width $clog2(WIDTH+1), used in S4.

Test Plan:
1. FP32 defaults, 0x3F800000 + 0x40000000, op_sub=0 → 0x40400000 after 5 cycles, all flags 0.
2. 0x3F800000 - 0x3F7FFFFF (op_sub=1) → 0x33800000. This checks a 24-bit normalisation shift. Also 0x40400000 - 0x40400000 → 0x00000000 with flag_zero=1.
3. Rounding: 0x3F800000 + 0x33800000 → 0x3F800000 (tie to even); 0x3F800000 + 0x33800001 → 0x3F800001; 0x3F800001 + 0x33800000 → 0x3F800002.
4. Specials:
   - 0x7F800000 - 0x7F800000 → 0x7FC00000 with flag_invalid=1.
   - 0x7F7FFFFF + 0x7F7FFFFF → 0x7F800000 with flag_overflow=1.
   - 0x80000000 + 0x80000000 → 0x80000000.
5. Backpressure: stream 8 back-to-back ops and drop out_ready for 3 cycles at cycle 6. Expect in_ready to fall during the stall, all 8 results in order with none lost or duplicated, and result held stable. Then assert reset with 3 ops in flight → out_valid=0 and no stale results afterwards.
6. Parameter sweep with EXP_W=5, MAN_W=10 (half precision): 0x3C00 + 0x4000 → 0x4200; 0x7BFF + 0x7BFF → 0x7C00 with flag_overflow=1.

Source files
------------

// File: rtl/fp_addsub_pipe_pkg.sv
// ============================================================================
// Module : fp_pkg
// Brief  : Shared widths, operand classes and encoding helpers for fp_addsub_pipe.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package fp_pkg;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;

  typedef enum logic [1:0] {FP_ZERO, FP_NORM, FP_INF, FP_NAN} fp_class_e;

  // Decision taken in S1 that overrides the datapath value at pack time
  typedef enum logic [1:0] {BP_NONE, BP_NAN, BP_INF, BP_ZERO} fp_bypass_e;

  function automatic int bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  function automatic int exp_all_ones(input int exp_w);
    return (1 << exp_w) - 1;
  endfunction

  function automatic logic [63:0] qnan(input int exp_w, input int man_w);
    logic [63:0] v;
    v = 64'(exp_all_ones(exp_w)) << man_w;
    v[man_w-1] = 1'b1;
    return v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fp_addsub_pipe_lzc.sv
// ============================================================================
// Module : fp_lzc
// Brief  : Combinational leading-zero counter; all-zero input returns WIDTH.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module fp_lzc #(
  parameter  int WIDTH = 8,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] i_data,
  output logic [CW-1:0]    o_count
);

  // Highest set bit wins because it is visited last
  always_comb begin
    o_count = CW'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (i_data[i]) o_count = CW'(WIDTH - 1 - i);
    end
  end

endmodule

`default_nettype wire

// File: rtl/fp_addsub_pipe.sv
// ============================================================================
// Module : fp_addsub_pipe
// Brief  : Five-stage parametrised floating-point add/sub, RNE, valid/ready.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module fp_addsub_pipe #(
  parameter  int EXP_W = fp_pkg::EXP_W,
  parameter  int MAN_W = fp_pkg::MAN_W,
  localparam int W     = EXP_W + MAN_W + 1
) (
  input  logic         clk_n,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         op_sub,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         flag_invalid,
  output logic         flag_overflow,
  output logic         flag_zero
);

  import fp_pkg::*;

  localparam int PW  = MAN_W + 4;
  localparam int LZW = $clog2(PW + 1);
  localparam int EW  = ((EXP_W > LZW) ? EXP_W : LZW) + 2;

  localparam logic [EXP_W-1:0] c_exp_ones = '1;
  localparam logic [EW-1:0]    c_exp_max  = EW'(exp_all_ones(EXP_W));
  localparam logic [63:0]      c_qnan64   = qnan(EXP_W, MAN_W);

  function automatic fp_class_e f_class(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] m);
    if (e == '0) return FP_ZERO;
    if (e == '1) return (m == '0) ? FP_INF : FP_NAN;
    return FP_NORM;
  endfunction

  logic w_en;
  assign w_en     = ~(out_valid & ~out_ready);
  assign in_ready = w_en;

  // ---------------- S1: unpack, flush, classify, swap
  logic             w_sa, w_sb;
  logic [EXP_W-1:0] w_ea, w_eb;
  logic [MAN_W-1:0] w_ma, w_mb;
  fp_class_e        w_ca, w_cb;
  logic             w_a_big;
  fp_bypass_e       w_bp;
  logic             w_bp_sign;

  assign w_sa    = a[W-1];
  assign w_sb    = b[W-1] ^ op_sub;
  assign w_ea    = a[W-2:MAN_W];
  assign w_eb    = b[W-2:MAN_W];
  assign w_ma    = (w_ea == '0) ? '0 : a[MAN_W-1:0];
  assign w_mb    = (w_eb == '0) ? '0 : b[MAN_W-1:0];
  assign w_ca    = f_class(w_ea, w_ma);
  assign w_cb    = f_class(w_eb, w_mb);
  assign w_a_big = ({w_ea, w_ma} >= {w_eb, w_mb});

  always_comb begin
    w_bp      = BP_NONE;
    w_bp_sign = 1'b0;
    if (w_ca == FP_NAN || w_cb == FP_NAN) begin
      w_bp = BP_NAN;
    end else if (w_ca == FP_INF && w_cb == FP_INF) begin
      if (w_sa != w_sb) begin
        w_bp = BP_NAN;
      end else begin
        w_bp      = BP_INF;
        w_bp_sign = w_sa;
      end
    end else if (w_ca == FP_INF) begin
      w_bp      = BP_INF;
      w_bp_sign = w_sa;
    end else if (w_cb == FP_INF) begin
      w_bp      = BP_INF;
      w_bp_sign = w_sb;
    end else if (w_ca == FP_ZERO && w_cb == FP_ZERO) begin
      w_bp      = BP_ZERO;
      w_bp_sign = w_sa & w_sb;
    end
  end

  logic             r_s1_valid, r_s1_sign, r_s1_eff_sub, r_s1_bp_sign;
  logic [EXP_W-1:0] r_s1_exp, r_s1_diff;
  logic [MAN_W:0]   r_s1_big, r_s1_small;
  fp_bypass_e       r_s1_bp;

  always_ff @(negedge clk_n or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid   <= 1'b0;
      r_s1_sign    <= 1'b0;
      r_s1_eff_sub <= 1'b0;
      r_s1_bp_sign <= 1'b0;
      r_s1_exp     <= '0;
      r_s1_diff    <= '0;
      r_s1_big     <= '0;
      r_s1_small   <= '0;
      r_s1_bp      <= BP_NONE;
    end else if (w_en) begin
      r_s1_valid   <= in_valid;
      r_s1_sign    <= w_a_big ? w_sa : w_sb;
      r_s1_eff_sub <= w_sa ^ w_sb;
      r_s1_bp_sign <= w_bp_sign;
      r_s1_exp     <= w_a_big ? w_ea : w_eb;
      r_s1_diff    <= w_a_big ? (w_ea - w_eb) : (w_eb - w_ea);
      r_s1_big     <= w_a_big ? {w_ea != '0, w_ma} : {w_eb != '0, w_mb};
      r_s1_small   <= w_a_big ? {w_eb != '0, w_mb} : {w_ea != '0, w_ma};
      r_s1_bp      <= w_bp;
    end
  end

  // ---------------- S2: align small operand with guard/round/sticky
  logic [PW-1:0] w_small_ext, w_shifted, w_lost_mask, w_aligned;
  logic          w_lost;

  assign w_small_ext = {r_s1_small, 3'b000};
  assign w_shifted   = w_small_ext >> r_s1_diff;
  assign w_lost_mask = ~({PW{1'b1}} << r_s1_diff);
  assign w_lost      = |(w_small_ext & w_lost_mask);
  assign w_aligned   = {w_shifted[PW-1:1], w_shifted[0] | w_lost};

  logic             r_s2_valid, r_s2_sign, r_s2_eff_sub, r_s2_bp_sign;
  logic [EXP_W-1:0] r_s2_exp;
  logic [PW-1:0]    r_s2_big, r_s2_small;
  fp_bypass_e       r_s2_bp;

  always_ff @(negedge clk_n or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid   <= 1'b0;
      r_s2_sign    <= 1'b0;
      r_s2_eff_sub <= 1'b0;
      r_s2_bp_sign <= 1'b0;
      r_s2_exp     <= '0;
      r_s2_big     <= '0;
      r_s2_small   <= '0;
      r_s2_bp      <= BP_NONE;
    end else if (w_en) begin
      r_s2_valid   <= r_s1_valid;
      r_s2_sign    <= r_s1_sign;
      r_s2_eff_sub <= r_s1_eff_sub;
      r_s2_bp_sign <= r_s1_bp_sign;
      r_s2_exp     <= r_s1_exp;
      r_s2_big     <= {r_s1_big, 3'b000};
      r_s2_small   <= w_aligned;
      r_s2_bp      <= r_s1_bp;
    end
  end

  // ---------------- S3: magnitude add / subtract (big >= small)
  logic [PW:0] w_sum;
  assign w_sum = r_s2_eff_sub ? ({1'b0, r_s2_big} - {1'b0, r_s2_small})
                              : ({1'b0, r_s2_big} + {1'b0, r_s2_small});

  logic             r_s3_valid, r_s3_sign, r_s3_bp_sign;
  logic [EXP_W-1:0] r_s3_exp;
  logic [PW:0]      r_s3_sum;
  fp_bypass_e       r_s3_bp;

  always_ff @(negedge clk_n or negedge rst_n) begin
    if (!rst_n) begin
      r_s3_valid   <= 1'b0;
      r_s3_sign    <= 1'b0;
      r_s3_bp_sign <= 1'b0;
      r_s3_exp     <= '0;
      r_s3_sum     <= '0;
      r_s3_bp      <= BP_NONE;
    end else if (w_en) begin
      r_s3_valid   <= r_s2_valid;
      r_s3_sign    <= r_s2_sign;
      r_s3_bp_sign <= r_s2_bp_sign;
      r_s3_exp     <= r_s2_exp;
      r_s3_sum     <= w_sum;
      r_s3_bp      <= r_s2_bp;
    end
  end

  // ---------------- S4: normalise
  logic [LZW-1:0] w_lz;
  logic [PW-1:0]  w_norm;
  logic [EW-1:0]  w_exp4, w_exp_base;

  fp_lzc #(.WIDTH(PW)) u_lzc (
    .i_data  (r_s3_sum[PW-1:0]),
    .o_count (w_lz)
  );

  assign w_exp_base = {{(EW-EXP_W){1'b0}}, r_s3_exp};
  assign w_norm     = r_s3_sum[PW] ? {r_s3_sum[PW:2], r_s3_sum[1] | r_s3_sum[0]}
                                   : (r_s3_sum[PW-1:0] << w_lz);
  assign w_exp4     = r_s3_sum[PW] ? (w_exp_base + EW'(1))
                                   : (w_exp_base - {{(EW-LZW){1'b0}}, w_lz});

  logic             r_s4_valid, r_s4_sign, r_s4_bp_sign, r_s4_zero;
  logic [EW-1:0]    r_s4_exp;
  logic [PW-1:0]    r_s4_norm;
  fp_bypass_e       r_s4_bp;

  always_ff @(negedge clk_n or negedge rst_n) begin
    if (!rst_n) begin
      r_s4_valid   <= 1'b0;
      r_s4_sign    <= 1'b0;
      r_s4_bp_sign <= 1'b0;
      r_s4_zero    <= 1'b0;
      r_s4_exp     <= '0;
      r_s4_norm    <= '0;
      r_s4_bp      <= BP_NONE;
    end else if (w_en) begin
      r_s4_valid   <= r_s3_valid;
      r_s4_sign    <= r_s3_sign;
      r_s4_bp_sign <= r_s3_bp_sign;
      r_s4_zero    <= (r_s3_sum == '0);
      r_s4_exp     <= w_exp4;
      r_s4_norm    <= w_norm;
      r_s4_bp      <= r_s3_bp;
    end
  end

  // ---------------- S5: round to nearest even, pack, apply bypass
  logic [MAN_W:0]   w_mant;
  logic [MAN_W+1:0] w_mant_r;
  logic             w_up, w_rcarry;
  logic [EW-1:0]    w_exp_r;
  logic [MAN_W-1:0] w_man_out;

  assign w_mant    = r_s4_norm[PW-1:3];
  assign w_up      = r_s4_norm[2] & (r_s4_norm[1] | r_s4_norm[0] | w_mant[0]);
  assign w_mant_r  = {1'b0, w_mant} + {{(MAN_W+1){1'b0}}, w_up};
  assign w_rcarry  = w_mant_r[MAN_W+1];
  assign w_exp_r   = r_s4_exp + {{(EW-1){1'b0}}, w_rcarry};
  assign w_man_out = w_rcarry ? w_mant_r[MAN_W:1] : w_mant_r[MAN_W-1:0];

  logic [W-1:0] w_res;
  logic         w_inv, w_ovf, w_zero;

  always_comb begin
    w_res  = {r_s4_sign, w_exp_r[EXP_W-1:0], w_man_out};
    w_inv  = 1'b0;
    w_ovf  = 1'b0;
    w_zero = 1'b0;
    case (r_s4_bp)
      BP_NAN: begin
        w_res = c_qnan64[W-1:0];
        w_inv = 1'b1;
      end
      BP_INF:  w_res = {r_s4_bp_sign, c_exp_ones, {MAN_W{1'b0}}};
      BP_ZERO: begin
        w_res  = {r_s4_bp_sign, {(W-1){1'b0}}};
        w_zero = 1'b1;
      end
      default: begin
        if (r_s4_zero) begin
          w_res  = '0;
          w_zero = 1'b1;
        end else if (r_s4_exp[EW-1] || r_s4_exp == '0) begin
          w_res  = {r_s4_sign, {(W-1){1'b0}}};
          w_zero = 1'b1;
        end else if (w_exp_r >= c_exp_max) begin
          w_res = {r_s4_sign, c_exp_ones, {MAN_W{1'b0}}};
          w_ovf = 1'b1;
        end
      end
    endcase
  end

  always_ff @(negedge clk_n or negedge rst_n) begin
    if (!rst_n) begin
      out_valid     <= 1'b0;
      result        <= '0;
      flag_invalid  <= 1'b0;
      flag_overflow <= 1'b0;
      flag_zero     <= 1'b0;
    end else if (w_en) begin
      out_valid     <= r_s4_valid;
      result        <= w_res;
      flag_invalid  <= w_inv;
      flag_overflow <= w_ovf;
      flag_zero     <= w_zero;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fp_addsub_pipe.sv
// ============================================================================
// Module : tb_fp_addsub_pipe
// Brief  : Directed vector table plus backpressure and reset sequences.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_fp_addsub_pipe;

  logic        clk_n = 1'b1;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, op_sub = 1'b0, out_ready = 1'b1;
  logic [31:0] a = '0, b = '0;
  logic        in_ready, out_valid, flag_invalid, flag_overflow, flag_zero;
  logic [31:0] result;

  logic        h_in_valid = 1'b0, h_op_sub = 1'b0, h_out_ready = 1'b1;
  logic [15:0] h_a = '0, h_b = '0;
  logic        h_in_ready, h_out_valid, h_flag_invalid, h_flag_overflow, h_flag_zero;
  logic [15:0] h_result;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_n = ~clk_n;

  fp_addsub_pipe u_dut (
    .clk_n(clk_n), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op_sub(op_sub), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flag_invalid(flag_invalid), .flag_overflow(flag_overflow),
    .flag_zero(flag_zero)
  );

  fp_addsub_pipe #(.EXP_W(5), .MAN_W(10)) u_dut_h (
    .clk_n(clk_n), .rst_n(rst_n), .in_valid(h_in_valid), .in_ready(h_in_ready),
    .op_sub(h_op_sub), .a(h_a), .b(h_b), .out_valid(h_out_valid), .out_ready(h_out_ready),
    .result(h_result), .flag_invalid(h_flag_invalid), .flag_overflow(h_flag_overflow),
    .flag_zero(h_flag_zero)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        op;
    logic        half;
    logic [31:0] res;
    logic [2:0]  flags; // {invalid, overflow, zero}
  } vec_t;

  vec_t vecs[22];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int          n;
    logic        ov;
    logic [31:0] ores;
    logic [2:0]  ofl;
    @(posedge clk_n);
    out_ready = 1'b1;
    if (v.half) begin
      h_in_valid = 1'b1; h_a = v.a[15:0]; h_b = v.b[15:0]; h_op_sub = v.op;
    end else begin
      in_valid = 1'b1; a = v.a; b = v.b; op_sub = v.op;
    end
    @(negedge clk_n);
    n  = 1;
    ov = 1'b0;
    while (n < 20) begin
      @(posedge clk_n);
      in_valid   = 1'b0;
      h_in_valid = 1'b0;
      #1;
      ov = v.half ? h_out_valid : out_valid;
      if (ov) break;
      @(negedge clk_n);
      n++;
    end
    ores = v.half ? {16'h0, h_result} : result;
    ofl  = v.half ? {h_flag_invalid, h_flag_overflow, h_flag_zero}
                  : {flag_invalid, flag_overflow, flag_zero};
    check($sformatf("vec%0d_latency", idx), 64'(n), 64'd5);
    check($sformatf("vec%0d_result", idx), 64'(ores), 64'(v.res));
    check($sformatf("vec%0d_flags", idx), 64'(ofl), 64'(v.flags));
    @(negedge clk_n);
  endtask

  logic [31:0] bp_b[8]   = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                             32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
  logic [31:0] bp_exp[8] = '{32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000,
                             32'h40C00000, 32'h40E00000, 32'h41000000, 32'h41100000};

  initial begin
    int issued, got, stalls, spurious, wait_n;

    vecs[0]  = '{32'h3F800000, 32'h40000000, 1'b0, 1'b0, 32'h40400000, 3'b000};
    vecs[1]  = '{32'h3F800000, 32'h3F7FFFFF, 1'b1, 1'b0, 32'h33800000, 3'b000};
    vecs[2]  = '{32'h40400000, 32'h40400000, 1'b1, 1'b0, 32'h00000000, 3'b001};
    vecs[3]  = '{32'h3F800000, 32'h33800000, 1'b0, 1'b0, 32'h3F800000, 3'b000};
    vecs[4]  = '{32'h3F800000, 32'h33800001, 1'b0, 1'b0, 32'h3F800001, 3'b000};
    vecs[5]  = '{32'h3F800001, 32'h33800000, 1'b0, 1'b0, 32'h3F800002, 3'b000};
    vecs[6]  = '{32'h7F800000, 32'h7F800000, 1'b1, 1'b0, 32'h7FC00000, 3'b100};
    vecs[7]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 1'b0, 32'h7F800000, 3'b010};
    vecs[8]  = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h80000000, 3'b001};
    vecs[9]  = '{32'h7FC00001, 32'h3F800000, 1'b0, 1'b0, 32'h7FC00000, 3'b100};
    vecs[10] = '{32'hFF800000, 32'h3F800000, 1'b0, 1'b0, 32'hFF800000, 3'b000};
    vecs[11] = '{32'h00000001, 32'h00000000, 1'b0, 1'b0, 32'h00000000, 3'b001};
    vecs[12] = '{32'h80000000, 32'h80000000, 1'b1, 1'b0, 32'h00000000, 3'b001};
    vecs[13] = '{32'h40000000, 32'h3F800000, 1'b1, 1'b0, 32'h3F800000, 3'b000};
    vecs[14] = '{32'hC0000000, 32'h3F800000, 1'b0, 1'b0, 32'hBF800000, 3'b000};
    vecs[15] = '{32'h3F800000, 32'h40000000, 1'b1, 1'b0, 32'hBF800000, 3'b000};
    vecs[16] = '{32'h00800001, 32'h00800000, 1'b1, 1'b0, 32'h00000000, 3'b001};
    vecs[17] = '{32'h7F800000, 32'h7F800000, 1'b0, 1'b0, 32'h7F800000, 3'b000};
    vecs[18] = '{32'h7F800000, 32'hFF800000, 1'b1, 1'b0, 32'h7F800000, 3'b000};
    vecs[19] = '{32'h00003C00, 32'h00004000, 1'b0, 1'b1, 32'h00004200, 3'b000};
    vecs[20] = '{32'h00007BFF, 32'h00007BFF, 1'b0, 1'b1, 32'h00007C00, 3'b010};
    vecs[21] = '{32'h00007C00, 32'h00007C00, 1'b1, 1'b1, 32'h00007E00, 3'b100};

    // Reset state
    repeat (3) @(posedge clk_n);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_flags", 64'({flag_invalid, flag_overflow, flag_zero}), 64'd0);
    rst_n = 1'b1;
    @(negedge clk_n);
    @(posedge clk_n);
    #1;
    check("rst_in_ready", 64'({in_ready, h_in_ready}), 64'b11);

    for (int i = 0; i < 22; i++) run_vec(i, vecs[i]);

    // Backpressure: 8 back-to-back ops, consumer stalls for 3 cycles from cycle 6
    issued = 0; got = 0; stalls = 0;
    for (int c = 0; c < 60 && got < 8; c++) begin
      @(posedge clk_n);
      out_ready = !(c >= 6 && c < 9);
      in_valid  = (issued < 8);
      a         = 32'h3F800000;
      b         = (issued < 8) ? bp_b[issued] : 32'h0;
      op_sub    = 1'b0;
      #1;
      if (out_valid) begin
        if (out_ready) begin
          check($sformatf("bp_result%0d", got), 64'(result), 64'(bp_exp[got]));
          got++;
        end else begin
          stalls++;
          check("bp_hold", 64'(result), 64'(bp_exp[got]));
          check("bp_in_ready_low", 64'(in_ready), 64'd0);
        end
      end
      if (in_valid && in_ready) issued++;
    end
    check("bp_count", 64'(got), 64'd8);
    check("bp_stall_cycles", 64'(stalls), 64'd3);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    spurious  = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk_n);
      #1;
      if (out_valid) spurious++;
    end
    check("bp_no_duplicate", 64'(spurious), 64'd0);

    // Reset with operations in flight
    for (int k = 0; k < 3; k++) begin
      @(posedge clk_n);
      in_valid = 1'b1; a = 32'h3F800000; b = 32'h40000000; op_sub = 1'b0;
    end
    @(posedge clk_n);
    in_valid = 1'b0;
    out_ready = 1'b0;
    wait_n = 0;
    #1;
    while (!out_valid && wait_n < 20) begin
      @(posedge clk_n);
      #1;
      wait_n++;
    end
    check("inflight_valid_before_rst", 64'(out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    check("inflight_rst_out_valid", 64'(out_valid), 64'd0);
    repeat (2) @(posedge clk_n);
    rst_n = 1'b1;
    out_ready = 1'b1;
    spurious = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk_n);
      #1;
      if (out_valid) spurious++;
    end
    check("inflight_no_stale", 64'(spurious), 64'd0);
    check("inflight_in_ready", 64'(in_ready), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
